// File: rtl/adc_capture_packer.sv
// Captures a burst of ADC samples, converts each to a LANE_W lane and packs LANES lanes per
// memory word, writing words sequentially into on-chip memory starting at BASE_ADDR.
module adc_capture_packer #(
  parameter int unsigned SAMPLE_W   = 14,
  parameter int unsigned LANE_W     = 16,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter bit          SIGNED_OUT = 1'b1
) (
  input  logic                       clk_100m,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic [SAMPLE_W-1:0]        sample_data,
  input  logic                       sample_or,
  input  logic                       capture_pulse,
  input  logic                       abort,
  output logic                       onchip_mem_chip_select,
  output logic                       onchip_mem_clken,
  output logic                       onchip_mem_write,
  output logic                       onchip_mem_read,
  output logic [ADDR_W-1:0]          onchip_mem_addr,
  output logic [LANES*LANE_W/8-1:0]  onchip_mem_byte_enable,
  output logic [LANES*LANE_W-1:0]    onchip_mem_write_data,
  output logic                       busy,
  output logic                       capture_done,
  output logic                       capture_aborted,
  output logic                       overrange_seen,
  output logic [ADDR_W:0]            words_written
);

  localparam int unsigned DataW     = LANES * LANE_W;
  localparam int unsigned BeW       = DataW / 8;
  localparam int unsigned LaneBytes = LANE_W / 8;
  localparam int unsigned CntW      = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StCapture, StFlush, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     lane_q;
  logic [DataW-1:0]    buf_q;
  logic [ADDR_W:0]     wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     words_q;
  logic                write_q;
  logic [DataW-1:0]    wdata_q;
  logic [BeW-1:0]      be_q;
  logic                aborted_q;
  logic                abort_pend_q;
  logic                ovr_q;

  logic [LANE_W-1:0]   lane_val;
  logic                accept;
  logic                word_full;
  logic [CntW:0]       fill_cnt;
  logic [DataW-1:0]    buf_ins;
  logic [BeW-1:0]      be_part;

  always_comb begin
    if (SIGNED_OUT) begin
      lane_val = {{(LANE_W-SAMPLE_W){~sample_data[SAMPLE_W-1]}}, ~sample_data[SAMPLE_W-1],
                  sample_data[SAMPLE_W-2:0]};
    end else begin
      lane_val = LANE_W'(sample_data);
    end
    accept    = (state_q == StCapture) && sample_valid;
    buf_ins   = buf_q | (DataW'(lane_val) << (lane_q * LANE_W));
    word_full = accept && (lane_q == CntW'(LANES - 1));
    // Lanes holding data once this cycle's sample (if any) is included.
    fill_cnt  = {1'b0, lane_q} + (CntW+1)'(accept);
    be_part   = '0;
    for (int unsigned b = 0; b < BeW; b++) begin
      be_part[b] = (b < 32'(fill_cnt) * LaneBytes);
    end
  end

  always_ff @(posedge clk_100m) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      buf_q        <= '0;
      wcnt_q       <= '0;
      addr_q       <= ADDR_W'(BASE_ADDR);
      words_q      <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      write_q <= 1'b0;
      if (write_q) begin
        addr_q  <= addr_q + 1'b1;
        words_q <= words_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (capture_pulse) begin
            state_q      <= StCapture;
            lane_q       <= '0;
            buf_q        <= '0;
            wcnt_q       <= '0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            words_q      <= '0;
            ovr_q        <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
          end
        end
        StCapture: begin
          if (accept) ovr_q <= ovr_q | sample_or;
          if (word_full) begin
            write_q <= 1'b1;
            wdata_q <= buf_ins;
            be_q    <= '1;
            buf_q   <= '0;
            lane_q  <= '0;
            wcnt_q  <= wcnt_q + 1'b1;
            // Final word or an abort: spend the write cycle in FLUSH, then finish.
            if (abort || (wcnt_q == (ADDR_W+1)'(NUM_WORDS - 1))) begin
              state_q      <= StFlush;
              abort_pend_q <= abort;
            end
          end else if (abort) begin
            lane_q <= '0;
            buf_q  <= '0;
            if (fill_cnt != '0) begin
              write_q      <= 1'b1;
              wdata_q      <= accept ? buf_ins : buf_q;
              be_q         <= be_part;
              state_q      <= StFlush;
              abort_pend_q <= 1'b1;
            end else begin
              state_q   <= StDone;
              aborted_q <= 1'b1;
            end
          end else if (accept) begin
            buf_q  <= buf_ins;
            lane_q <= lane_q + 1'b1;
          end
        end
        StFlush: begin
          state_q      <= StDone;
          aborted_q    <= abort_pend_q;
          abort_pend_q <= 1'b0;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy                   = (state_q != StIdle);
  assign onchip_mem_chip_select = busy;
  assign onchip_mem_clken       = busy;
  assign onchip_mem_write       = write_q;
  assign onchip_mem_read        = 1'b0;
  assign onchip_mem_addr        = addr_q;
  assign onchip_mem_byte_enable = be_q;
  assign onchip_mem_write_data  = wdata_q;
  assign capture_done           = (state_q == StDone);
  assign capture_aborted        = aborted_q;
  assign overrange_seen         = ovr_q;
  assign words_written          = words_q;

endmodule
